// File: rtl/time_set_controller.sv
// Button-driven editor for the clock/date set interface: debounced buttons step through fields and commit.
// Button press acts 6 cycles after the raw edge is sampled; set strobes are registered one cycle after commit.
module time_set_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int YEAR_MIN        = 2000,
    parameter int YEAR_MAX        = 2099
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [7:0]  cur_sec,
    input  logic [7:0]  cur_min,
    input  logic [7:0]  cur_hour,
    input  logic [7:0]  cur_day,
    input  logic [7:0]  cur_month,
    input  logic [15:0] cur_year,
    output logic [7:0]  out_sec,
    output logic [7:0]  out_min,
    output logic [7:0]  out_hour,
    output logic [7:0]  out_day,
    output logic [7:0]  out_month,
    output logic [15:0] out_year,
    output logic        set_time,
    output logic        set_date,
    output logic        edit_active,
    output logic [2:0]  edit_field
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOUR  = 3'd1,
        S_MIN   = 3'd2,
        S_SEC   = 3'd3,
        S_DAY   = 3'd4,
        S_MONTH = 3'd5,
        S_YEAR  = 3'd6
    } state_t;

    // Button bit order: 0 mode, 1 next, 2 up, 3 down (also the priority order).
    logic [3:0]  raw;
    logic [3:0]  sync1_q, sync2_q, deb_q, press_q;
    logic [15:0] cnt_q [4];

    assign raw = {btn_down, btn_up, btn_next, btn_mode};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            press_q <= '0;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= 16'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q[i]   <= sync2_q[i];
                    cnt_q[i]   <= '0;
                    press_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [15:0] y);
        logic leap;
        leap = (((y % 16'd4) == 16'd0) && ((y % 16'd100) != 16'd0)) || ((y % 16'd400) == 16'd0);
        case (m)
            8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd10, 8'd12: return 8'd31;
            8'd2:    return leap ? 8'd29 : 8'd28;
            default: return 8'd30;
        endcase
    endfunction

    // Out-of-range values snap to the opposite bound, which also repairs bad snapshots.
    function automatic logic [15:0] wrap(input logic [15:0] v, input logic [15:0] lo,
                                         input logic [15:0] hi, input logic up);
        if (up) return (v >= hi) ? lo : v + 16'd1;
        return (v <= lo) ? hi : v - 16'd1;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [7:0]  day_q, day_d, month_q, month_d;
    logic [15:0] year_q, year_d;
    logic        set_time_q, set_time_d, set_date_q, set_date_d;
    logic [15:0] wr;
    logic [7:0]  new_dim;
    logic        up;

    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        day_d      = day_q;
        month_d    = month_q;
        year_d     = year_q;
        set_time_d = 1'b0;
        set_date_d = 1'b0;
        wr         = '0;
        new_dim    = '0;
        up         = press_q[2];
        if (press_q[0]) begin
            if (state_q == S_IDLE) begin
                sec_d   = cur_sec;
                min_d   = cur_min;
                hour_d  = cur_hour;
                day_d   = cur_day;
                month_d = cur_month;
                year_d  = cur_year;
                state_d = S_HOUR;
            end else begin
                state_d = S_IDLE;
            end
        end else if (state_q != S_IDLE && press_q[1]) begin
            case (state_q)
                S_HOUR:  state_d = S_MIN;
                S_MIN:   state_d = S_SEC;
                S_SEC:   begin state_d = S_DAY; set_time_d = 1'b1; end
                S_DAY:   state_d = S_MONTH;
                S_MONTH: state_d = S_YEAR;
                S_YEAR:  begin state_d = S_IDLE; set_date_d = 1'b1; end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && (press_q[2] || press_q[3])) begin
            case (state_q)
                S_HOUR: begin wr = wrap({8'd0, hour_q}, 16'd0, 16'd23, up); hour_d = wr[7:0]; end
                S_MIN:  begin wr = wrap({8'd0, min_q}, 16'd0, 16'd59, up); min_d = wr[7:0]; end
                S_SEC:  begin wr = wrap({8'd0, sec_q}, 16'd0, 16'd59, up); sec_d = wr[7:0]; end
                S_DAY: begin
                    wr    = wrap({8'd0, day_q}, 16'd1, {8'd0, days_in_month(month_q, year_q)}, up);
                    day_d = wr[7:0];
                end
                S_MONTH: begin
                    wr      = wrap({8'd0, month_q}, 16'd1, 16'd12, up);
                    month_d = wr[7:0];
                    new_dim = days_in_month(month_d, year_q);
                    if (day_q > new_dim) day_d = new_dim;
                end
                S_YEAR: begin
                    year_d  = wrap(year_q, 16'(YEAR_MIN), 16'(YEAR_MAX), up);
                    new_dim = days_in_month(month_q, year_d);
                    if (day_q > new_dim) day_d = new_dim;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sec_q      <= 8'd0;
            min_q      <= 8'd0;
            hour_q     <= 8'd0;
            day_q      <= 8'd1;
            month_q    <= 8'd1;
            year_q     <= 16'd2020;
            set_time_q <= 1'b0;
            set_date_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            day_q      <= day_d;
            month_q    <= month_d;
            year_q     <= year_d;
            set_time_q <= set_time_d;
            set_date_q <= set_date_d;
        end
    end

    assign out_sec     = sec_q;
    assign out_min     = min_q;
    assign out_hour    = hour_q;
    assign out_day     = day_q;
    assign out_month   = month_q;
    assign out_year    = year_q;
    assign set_time    = set_time_q;
    assign set_date    = set_date_q;
    assign edit_active = (state_q != S_IDLE);
    assign edit_field  = state_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: directed scenarios plus random button traffic vs a field-table model.
module tb_time_set_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [7:0]  cur_sec = 8'd0, cur_min = 8'd0, cur_hour = 8'd0, cur_day = 8'd1, cur_month = 8'd1;
    logic [15:0] cur_year = 16'd2020;
    logic [7:0]  out_sec, out_min, out_hour, out_day, out_month;
    logic [15:0] out_year;
    logic        set_time, set_date, edit_active;
    logic [2:0]  edit_field;

    time_set_controller #(.DEBOUNCE_CYCLES(4), .YEAR_MIN(2000), .YEAR_MAX(2099)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
        .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
        .out_sec(out_sec), .out_min(out_min), .out_hour(out_hour),
        .out_day(out_day), .out_month(out_month), .out_year(out_year),
        .set_time(set_time), .set_date(set_date),
        .edit_active(edit_active), .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: field table indexed by edit_field number (1 hour .. 6 year), 0 unused.
    int m_val [7];
    int m_field;
    int m_st, m_sd;

    int st_cnt = 0, sd_cnt = 0;
    logic [23:0] st_snap;
    logic [2:0]  st_field, sd_field;
    logic        sd_active;

    always @(negedge clk) begin
        if (set_time) begin
            st_cnt++;
            st_snap  = {out_hour, out_min, out_sec};
            st_field = edit_field;
        end
        if (set_date) begin
            sd_cnt++;
            sd_field  = edit_field;
            sd_active = edit_active;
        end
    end

    logic [59:0] dut_vec;
    assign dut_vec = {out_hour, out_min, out_sec, out_day, out_month, out_year, edit_field, edit_active};

    function automatic logic [59:0] exp_vec();
        return {8'(m_val[1]), 8'(m_val[2]), 8'(m_val[3]), 8'(m_val[4]), 8'(m_val[5]),
                16'(m_val[6]), 3'(m_field), (m_field != 0)};
    endfunction

    function automatic int dim(input int m, input int y);
        bit leap;
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        if (m == 2) return leap ? 29 : 28;
        if (m == 1 || m == 3 || m == 5 || m == 7 || m == 8 || m == 10 || m == 12) return 31;
        return 30;
    endfunction

    function automatic int lo_of(input int f);
        return (f >= 4 && f <= 5) ? 1 : (f == 6) ? 2000 : 0;
    endfunction

    function automatic int hi_of(input int f);
        case (f)
            1: return 23;
            2, 3: return 59;
            4: return dim(m_val[5], m_val[6]);
            5: return 12;
            default: return 2099;
        endcase
    endfunction

    task automatic model_reset();
        m_val   = '{0, 0, 0, 0, 1, 1, 2020};
        m_field = 0;
    endtask

    task automatic model_event(input logic [3:0] m);
        int lo, hi;
        if (m[0]) begin
            if (m_field == 0) begin
                m_val   = '{0, int'(cur_hour), int'(cur_min), int'(cur_sec),
                            int'(cur_day), int'(cur_month), int'(cur_year)};
                m_field = 1;
            end else m_field = 0;
        end else if (m_field != 0 && m[1]) begin
            if (m_field == 3) m_st++;
            if (m_field == 6) begin m_sd++; m_field = 0; end
            else m_field++;
        end else if (m_field != 0 && (m[2] || m[3])) begin
            lo = lo_of(m_field);
            hi = hi_of(m_field);
            if (m[2]) m_val[m_field] = (m_val[m_field] >= hi) ? lo : m_val[m_field] + 1;
            else      m_val[m_field] = (m_val[m_field] <= lo) ? hi : m_val[m_field] - 1;
            if ((m_field == 5 || m_field == 6) && m_val[4] > dim(m_val[5], m_val[6]))
                m_val[4] = dim(m_val[5], m_val[6]);
        end
    endtask

    // m bits: 0 mode, 1 next, 2 up, 3 down. Held and released long enough for full debounce.
    task automatic press(input logic [3:0] m);
        @(negedge clk);
        {btn_down, btn_up, btn_next, btn_mode} = m;
        repeat (10) @(negedge clk);
        {btn_down, btn_up, btn_next, btn_mode} = 4'b0000;
        repeat (10) @(negedge clk);
        model_event(m);
    endtask

    task automatic set_cur(input int h, input int mi, input int s, input int d, input int mo, input int y);
        cur_hour = 8'(h); cur_min = 8'(mi); cur_sec = 8'(s);
        cur_day = 8'(d); cur_month = 8'(mo); cur_year = 16'(y);
    endtask

    task automatic hard_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        m_st = 0; m_sd = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_vec !== {8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 16'd2020, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_outputs got %h want %h", dut_vec, exp_vec());
        end
        n_checks++;
        if ({set_time, set_date} !== 2'b00) begin
            n_fail++; $display("FAIL reset_strobes got %b want 00", {set_time, set_date});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_glitch();
        set_cur(13, 45, 7, 28, 2, 2023);
        @(negedge clk);
        btn_up = 1'b1; btn_mode = 1'b1;
        repeat (3) @(negedge clk);
        btn_up = 1'b0; btn_mode = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL glitch_no_event got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_debounce_latency();
        set_cur(13, 45, 7, 28, 2, 2023);
        @(negedge clk);
        btn_mode = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (edit_field !== 3'd0) begin
            n_fail++; $display("FAIL mode_latency_early got %0d want 0", edit_field);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (edit_field !== 3'd1) begin
            n_fail++; $display("FAIL mode_latency_exact got %0d want 1", edit_field);
        end
        @(negedge clk);
        btn_mode = 1'b0;
        repeat (10) @(negedge clk);
        model_event(4'b0001);
        n_checks++;
        if (dut_vec !== {8'd13, 8'd45, 8'd7, 8'd28, 8'd2, 16'd2023, 3'd1, 1'b1}) begin
            n_fail++; $display("FAIL snapshot got %h want %h", dut_vec, exp_vec());
        end
        press(4'b0001);
    endtask

    task automatic test_wrap();
        set_cur(23, 0, 30, 15, 6, 2099);
        press(4'b0001);
        press(4'b0100);
        n_checks++;
        if (out_hour !== 8'd0) begin n_fail++; $display("FAIL hour_up_wrap got %0d want 0", out_hour); end
        press(4'b1000);
        n_checks++;
        if (out_hour !== 8'd23) begin n_fail++; $display("FAIL hour_down_wrap got %0d want 23", out_hour); end
        press(4'b0010);
        press(4'b1000);
        n_checks++;
        if (out_min !== 8'd59) begin n_fail++; $display("FAIL min_down_wrap got %0d want 59", out_min); end
        repeat (4) press(4'b0010);
        press(4'b0100);
        n_checks++;
        if (out_year !== 16'd2000) begin n_fail++; $display("FAIL year_up_wrap got %0d want 2000", out_year); end
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL wrap_model got %h want %h", dut_vec, exp_vec()); end
        press(4'b0001);
    endtask

    task automatic test_commit();
        int st0, sd0;
        st0 = st_cnt; sd0 = sd_cnt;
        set_cur(23, 59, 58, 10, 5, 2030);
        press(4'b0001);
        set_cur(0, 0, 1, 11, 5, 2030);
        repeat (3) press(4'b0010);
        n_checks++;
        if (st_cnt - st0 !== 1) begin n_fail++; $display("FAIL set_time_pulses got %0d want 1", st_cnt - st0); end
        n_checks++;
        if (st_snap !== {8'd23, 8'd59, 8'd58} || st_field !== 3'd4) begin
            n_fail++; $display("FAIL set_time_values got %h field %0d want 173b3a field 4", st_snap, st_field);
        end
        repeat (3) press(4'b0010);
        n_checks++;
        if (sd_cnt - sd0 !== 1 || sd_field !== 3'd0 || sd_active !== 1'b0) begin
            n_fail++; $display("FAIL set_date_pulse got %0d field %0d act %b want 1 0 0", sd_cnt - sd0, sd_field, sd_active);
        end
        n_checks++;
        if (dut_vec !== {8'd23, 8'd59, 8'd58, 8'd10, 8'd5, 16'd2030, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL commit_hold got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_clamp();
        set_cur(12, 0, 0, 31, 1, 2024);
        press(4'b0001);
        repeat (4) press(4'b0010);
        press(4'b0100);
        n_checks++;
        if ({out_month, out_day} !== {8'd2, 8'd29}) begin
            n_fail++; $display("FAIL clamp_month got %0d/%0d want 2/29", out_month, out_day);
        end
        press(4'b0010);
        press(4'b0100);
        n_checks++;
        if ({out_year, out_day} !== {16'd2025, 8'd28}) begin
            n_fail++; $display("FAIL clamp_year got %0d day %0d want 2025 day 28", out_year, out_day);
        end
        press(4'b0001);
        set_cur(12, 0, 0, 28, 2, 2100);
        press(4'b0001);
        repeat (3) press(4'b0010);
        press(4'b0100);
        n_checks++;
        if (out_day !== 8'd1) begin n_fail++; $display("FAIL day_2100_wrap got %0d want 1", out_day); end
        press(4'b0001);
        n_checks++;
        if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL clamp_model got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_same_cycle();
        int st0;
        st0 = st_cnt;
        set_cur(10, 20, 30, 5, 5, 2050);
        press(4'b0001);
        press(4'b0010);
        press(4'b0011);
        n_checks++;
        if (edit_field !== 3'd0 || edit_active !== 1'b0 || st_cnt !== st0) begin
            n_fail++; $display("FAIL mode_next_abort got field %0d act %b strobes %0d want 0 0 0", edit_field, edit_active, st_cnt - st0);
        end
        press(4'b0001);
        press(4'b1100);
        n_checks++;
        if (out_hour !== 8'd11) begin n_fail++; $display("FAIL up_down_prio got %0d want 11", out_hour); end
        press(4'b0001);
    endtask

    task automatic test_random();
        logic [3:0] m;
        for (int i = 0; i < 60; i++) begin
            set_cur($urandom_range(0, 30), $urandom_range(0, 70), $urandom_range(0, 70),
                    $urandom_range(0, 33), $urandom_range(0, 14), $urandom_range(1990, 2110));
            if ($urandom_range(0, 4) == 0) m = 4'($urandom_range(1, 15));
            else m = 4'b0001 << $urandom_range(0, 3);
            if (m_field == 0 && $urandom_range(0, 1) == 1) m = 4'b0001;
            press(m);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_%0d mask %b got %h want %h", i, m, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (st_cnt !== m_st || sd_cnt !== m_sd) begin
            n_fail++; $display("FAIL random_strobes got %0d/%0d want %0d/%0d", st_cnt, sd_cnt, m_st, m_sd);
        end
    endtask

    task automatic test_reset_mid_edit();
        int sd0;
        if (m_field != 0) press(4'b0001);
        set_cur(8, 9, 10, 20, 7, 2040);
        press(4'b0001);
        repeat (3) press(4'b0010);
        sd0 = sd_cnt;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec !== {8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 16'd2020, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_mid_edit got %h", dut_vec);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (20) @(negedge clk);
        n_checks++;
        if (sd_cnt !== sd0 || set_date !== 1'b0) begin
            n_fail++; $display("FAIL no_date_after_reset got %0d want %0d", sd_cnt, sd0);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_debounce_latency();
        test_wrap();
        test_commit();
        test_clamp();
        test_same_cycle();
        hard_reset();
        test_random();
        test_reset_mid_edit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
